config_chain_loader: RTL and testbench

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/cfg_loader_pkg.sv | 23 ++
 rtl/cfg_shift_reg.sv | 63 ++++++
 rtl/config_chain_loader.sv | 154 +++++++++++++++
 tb/tb_config_chain_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration chain loader.
//
// Contents:
//   state_t        - loader FSM state encoding (IDLE/LOAD/VERIFY/DONE)
//   MAX_CHAIN_LEN  - largest chain length the loader is intended for
//   cnt_width()    - width of the per-pass bit counter for a given chain length
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int MAX_CHAIN_LEN = 1024;

  // Counter must be able to hold CHAIN_LEN itself without wrapping.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Shift/capture datapath for the configuration chain loader.
//
// Holds the image being driven into the scan chain and the image read back
// out of it. The drive register rotates, so after CHAIN_LEN shifts it holds
// the original word again and a second identical pass can follow.
//
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous active-high reset
//   i_load       - load i_word into the drive register
//   i_word       - configuration image (bit k ends in chain stage k)
//   i_shift      - advance one bit this cycle
//   i_capture    - with i_shift, capture i_serial into the readback register
//   i_serial     - serial data arriving from the chain tail
//   o_serial     - serial data for the chain head (MSB of drive register)
//   o_read_word  - captured readback image (first captured bit at MSB)
//   o_mismatch   - returning bit differs from the bit being driven
import cfg_loader_pkg::*;

module cfg_shift_reg #(
  parameter int CHAIN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [CHAIN_LEN-1:0] i_word,
  input  logic                 i_shift,
  input  logic                 i_capture,
  input  logic                 i_serial,
  output logic                 o_serial,
  output logic [CHAIN_LEN-1:0] o_read_word,
  output logic                 o_mismatch
);

  logic [CHAIN_LEN-1:0] r_data;
  logic [CHAIN_LEN-1:0] r_cap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cap  <= '0;
    end else begin
      if (i_load) begin
        r_data <= i_word;
      end else if (i_shift) begin
        // Rotate left; for CHAIN_LEN=1 this degenerates to a hold.
        r_data <= (r_data << 1) | (r_data >> (CHAIN_LEN - 1));
      end
      if (i_shift && i_capture) begin
        r_cap    <= r_cap << 1;
        r_cap[0] <= i_serial;
      end
    end
  end

  assign o_serial    = r_data[CHAIN_LEN-1];
  assign o_read_word = r_cap;

  // In a verify pass the chain already holds the image, so the bit leaving
  // the tail must equal the bit entering the head on the same cycle.
  assign o_mismatch  = (i_serial != r_data[CHAIN_LEN-1]);

endmodule

// File: rtl/config_chain_loader.sv
// Serial loader for a configuration scan chain (e.g. a carry-in manager).
//
// Shifts a CHAIN_LEN-bit image into the chain MSB first, capturing the old
// chain contents as they fall out of the tail. Optionally re-shifts the same
// image a second time and flags any bit that does not come back as written.
//
// Ports:
//   clk                  - clock, rising edge
//   reset                - synchronous active-high reset
//   start                - load request, sampled only in IDLE
//   verify_en            - sampled with start; request a readback pass
//   cfg_word             - image; bit k is left in chain stage k
//   busy                 - state is not IDLE
//   done                 - one-cycle completion pulse
//   verify_err           - sticky mismatch flag from the last verify pass
//   read_word            - previous chain contents captured during LOAD
//   configuration_input  - serial data to chain head
//   configuration_enable - chain shift enable
//   configuration_output - serial data from chain tail
//   dbg_state            - current FSM state encoding
//
// Handshake: a request is accepted on the edge where start=1 and busy=0 (and
// the FSM is not in DONE). busy rises the cycle after acceptance and stays
// high through the DONE cycle; done pulses for exactly that final cycle.
// start is ignored at all other times; no request is queued.
import cfg_loader_pkg::*;

module config_chain_loader #(
  parameter int CHAIN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 verify_en,
  input  logic [CHAIN_LEN-1:0] cfg_word,
  output logic                 busy,
  output logic                 done,
  output logic                 verify_err,
  output logic [CHAIN_LEN-1:0] read_word,
  output logic                 configuration_input,
  output logic                 configuration_enable,
  input  logic                 configuration_output,
  output logic [1:0]           dbg_state
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] TERM = CW'(CHAIN_LEN - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_verify_en;
  logic            r_verify_err;

  logic            w_load;
  logic            w_shift;
  logic            w_capture;
  logic            w_last;
  logic            w_serial_out;
  logic            w_mismatch;

  assign w_last = (r_cnt == TERM);

  // Next-state and datapath controls. Everything here depends only on
  // registered state and start, never on configuration_output.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_shift   = 1'b1;
        w_capture = 1'b1;
        if (w_last) begin
          w_next = r_verify_en ? VERIFY : DONE;
        end
      end
      VERIFY: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bit counter: cleared on acceptance and at the end of each pass, so it
  // never counts past TERM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_load || (w_shift && w_last)) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_verify_en  <= 1'b0;
      r_verify_err <= 1'b0;
    end else if (w_load) begin
      r_verify_en  <= verify_en;
      r_verify_err <= 1'b0;
    end else if ((r_state == VERIFY) && w_mismatch) begin
      r_verify_err <= 1'b1;
    end
  end

  cfg_shift_reg #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_shift (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_word      (cfg_word),
    .i_shift     (w_shift),
    .i_capture   (w_capture),
    .i_serial    (configuration_output),
    .o_serial    (w_serial_out),
    .o_read_word (read_word),
    .o_mismatch  (w_mismatch)
  );

  assign busy                 = (r_state != IDLE);
  assign done                 = (r_state == DONE);
  assign verify_err           = r_verify_err;
  assign configuration_enable = w_shift;
  assign configuration_input  = w_shift ? w_serial_out : 1'b0;
  assign dbg_state            = r_state;

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- CHAIN_LEN=4 instance ----------------
  logic       start4 = 1'b0;
  logic       ver4 = 1'b0;
  logic [3:0] cfg4 = 4'd0;
  logic       busy4, done4, verr4, cfg_in4, cfg_en4, cfg_out4;
  logic [3:0] rd4;
  logic [1:0] st4;
  logic       force_zero = 1'b0;

  // Carry-in manager chain model: stage 0 CARRYINREG, 1 MREG,
  // 2 IS_CARRYIN_INVERTED, 3 IS_RSTALLCARRYIN_INVERTED (tail).
  logic [3:0] chain4 = 4'd0;
  always @(posedge clk) if (cfg_en4) chain4 <= {chain4[2:0], cfg_in4};
  assign cfg_out4 = force_zero ? 1'b0 : chain4[3];

  config_chain_loader #(.CHAIN_LEN(4)) dut4 (
    .clk                  (clk),
    .reset                (reset),
    .start                (start4),
    .verify_en            (ver4),
    .cfg_word             (cfg4),
    .busy                 (busy4),
    .done                 (done4),
    .verify_err           (verr4),
    .read_word            (rd4),
    .configuration_input  (cfg_in4),
    .configuration_enable (cfg_en4),
    .configuration_output (cfg_out4),
    .dbg_state            (st4)
  );

  // ---------------- CHAIN_LEN=1 instance ----------------
  logic       start1 = 1'b0;
  logic       ver1 = 1'b0;
  logic [0:0] cfg1 = 1'b0;
  logic       busy1, done1, verr1, cfg_in1, cfg_en1, cfg_out1;
  logic [0:0] rd1;
  logic [1:0] st1;

  logic chain1 = 1'b0;
  always @(posedge clk) if (cfg_en1) chain1 <= cfg_in1;
  assign cfg_out1 = chain1;

  config_chain_loader #(.CHAIN_LEN(1)) dut1 (
    .clk                  (clk),
    .reset                (reset),
    .start                (start1),
    .verify_en            (ver1),
    .cfg_word             (cfg1),
    .busy                 (busy1),
    .done                 (done1),
    .verify_err           (verr1),
    .read_word            (rd1),
    .configuration_input  (cfg_in1),
    .configuration_enable (cfg_en1),
    .configuration_output (cfg_out1),
    .dbg_state            (st1)
  );

  // ---------------- scoreboard / checker ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Results of the last run4 pass, cycle numbers relative to acceptance edge.
  int          en_cnt, en_first, en_last, done_cnt, done_cyc;
  logic        err_at_done, busy_after_rst, en_after_rst;
  logic [15:0] in_seq;

  // ---------------- driver ----------------
  // Called at a negedge. Accepts a request on the next edge (cycle 0), then
  // observes cycles 1..ncyc. start is pulsed in cycles s1/s2 and reset in
  // cycle rst_at (use -1 for none).
  task automatic run4(input logic [3:0] word, input logic ver,
                      input int s1, input int s2, input int rst_at, input int ncyc);
    en_cnt = 0; en_first = -1; en_last = -1; done_cnt = 0; done_cyc = -1;
    err_at_done = 1'bx; busy_after_rst = 1'bx; en_after_rst = 1'bx; in_seq = '0;
    cfg4 = word; ver4 = ver; start4 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      start4 = (c == s1) || (c == s2);
      reset  = (c == rst_at);
      if (cfg_en4) begin
        en_cnt++;
        if (en_first < 0) en_first = c;
        en_last = c;
        in_seq = {in_seq[14:0], cfg_in4};
      end
      if (done4) begin
        done_cnt++;
        done_cyc = c;
        err_at_done = verr4;
      end
      if (c == rst_at + 1) begin
        busy_after_rst = busy4;
        en_after_rst = cfg_en4;
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    reset  = 1'b0;
    ver4   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int en1_cnt, en1_first, en1_last, done1_cyc;
    logic err1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_verr", verr4, 1'b0);
    check("rst_read", rd4, 4'd0);
    check("rst_en", cfg_en4, 1'b0);
    check("rst_cin", cfg_in4, 1'b0);
    check("rst_state", st4, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    // Load 1011 without verify, old chain is all zero
    run4(4'b1011, 1'b0, -1, -1, -1, 10);
    check("l1_en_cnt", en_cnt, 4);
    check("l1_en_first", en_first, 1);
    check("l1_en_last", en_last, 4);
    check("l1_done_cyc", done_cyc, 5);
    check("l1_done_cnt", done_cnt, 1);
    check("l1_in_seq", in_seq, 16'h000B);
    check("l1_read", rd4, 4'b0000);
    check("l1_chain", chain4, 4'b1011);

    // Load 0110 without verify, read back 1011
    run4(4'b0110, 1'b0, -1, -1, -1, 10);
    check("l2_done_cyc", done_cyc, 5);
    check("l2_read", rd4, 4'b1011);
    check("l2_carryinreg", chain4[0], 1'b0);
    check("l2_mreg", chain4[1], 1'b1);
    check("l2_is_carryin_inv", chain4[2], 1'b1);
    check("l2_is_rstall_inv", chain4[3], 1'b0);
    check("l2_state_idle", st4, 2'd0);

    // Load 1001 with verify
    run4(4'b1001, 1'b1, -1, -1, -1, 14);
    check("v1_en_cnt", en_cnt, 8);
    check("v1_en_first", en_first, 1);
    check("v1_en_last", en_last, 8);
    check("v1_done_cyc", done_cyc, 9);
    check("v1_done_cnt", done_cnt, 1);
    check("v1_in_seq", in_seq, 16'h0099);
    check("v1_err", err_at_done, 1'b0);
    check("v1_read", rd4, 4'b0110);
    check("v1_chain", chain4, 4'b1001);

    // Tail forced to 0, load 0001 with verify: last bit mismatches
    force_zero = 1'b1;
    run4(4'b0001, 1'b1, -1, -1, -1, 14);
    check("v2_done_cyc", done_cyc, 9);
    check("v2_err_at_done", err_at_done, 1'b1);
    check("v2_err_held", verr4, 1'b1);
    check("v2_read", rd4, 4'b0000);
    force_zero = 1'b0;

    // start pulsed in LOAD (cycle 2) and in DONE (cycle 5): both ignored
    run4(4'b1100, 1'b0, 2, 5, -1, 14);
    check("s_en_cnt", en_cnt, 4);
    check("s_done_cnt", done_cnt, 1);
    check("s_done_cyc", done_cyc, 5);
    check("s_read", rd4, 4'b0001);
    check("s_chain", chain4, 4'b1100);
    check("s_err_cleared", verr4, 1'b0);

    // Reset in cycle 2 of LOAD aborts without done
    run4(4'b1111, 1'b0, -1, -1, 2, 10);
    check("r_en_after", en_after_rst, 1'b0);
    check("r_busy_after", busy_after_rst, 1'b0);
    check("r_done_cnt", done_cnt, 0);
    check("r_en_cnt", en_cnt, 2);
    check("r_read", rd4, 4'b0000);

    // Subsequent load completes normally
    run4(4'b0101, 1'b0, -1, -1, -1, 10);
    check("r2_done_cyc", done_cyc, 5);
    check("r2_done_cnt", done_cnt, 1);
    check("r2_chain", chain4, 4'b0101);

    // CHAIN_LEN=1, load 1 with verify
    en1_cnt = 0; en1_first = -1; en1_last = -1; done1_cyc = -1; err1 = 1'bx;
    cfg1 = 1'b1; ver1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (cfg_en1) begin
        en1_cnt++;
        if (en1_first < 0) en1_first = c;
        en1_last = c;
      end
      if (done1) begin
        done1_cyc = c;
        err1 = verr1;
      end
      @(negedge clk);
    end
    check("n1_en_cnt", en1_cnt, 2);
    check("n1_en_first", en1_first, 1);
    check("n1_en_last", en1_last, 2);
    check("n1_done_cyc", done1_cyc, 3);
    check("n1_err", err1, 1'b0);
    check("n1_chain", chain1, 1'b1);
    check("n1_read", rd1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
